// File: rtl/uart_tx.sv
// Serial transmitter: start bit, 8 data bits LSB first, optional even parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_o,
    input  logic       send_req,
    output logic       busy,
    output logic       send_ack,
    output logic       txd
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        txd_n, busy_n, ack_n;
    logic        bit_done;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_bit_n;
`endif

    assign bit_done = (baud_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            send_ack <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            txd      <= txd_n;
            busy     <= busy_n;
            send_ack <= ack_n;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
`ifdef UART_TX_PARITY_EN
        par_bit_n  = par_bit;
`endif
        if (state != IDLE)
            baud_cnt_n = bit_done ? 16'd0 : baud_cnt + 16'd1;

        case (state)
            IDLE: begin
                if (send_req) begin
                    state_n    = START;
                    shreg_n    = data_o;
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
`ifdef UART_TX_PARITY_EN
                    par_bit_n  = ^data_o;
`endif
                end
            end
            START: begin
                if (bit_done)
                    state_n = DATA;
            end
            DATA: begin
                // Shift on each boundary so shreg[0] is always the bit on the line.
                if (bit_done) begin
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n   = PARITY;
`else
                        state_n   = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done)
                    state_n = STOP;
            end
`endif
            STOP: begin
                // bit_idx is reused here to count stop bits.
                if (bit_done) begin
                    if (bit_idx == LAST_STOP) begin
                        state_n   = IDLE;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        txd_n  = 1'b1;
        busy_n = (state_n != IDLE);
        ack_n  = (state_n == STOP) && (baud_cnt_n == LAST_CNT) && (bit_idx_n == LAST_STOP);
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_n = par_bit_n;
`endif
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover 1/1, 2/2 and 4/1
// (CLKS_PER_BIT/STOP_BITS) configurations.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] a_data, b_data, c_data;
    logic a_req, b_req, c_req;
    logic a_busy, a_ack, a_txd;
    logic b_busy, b_ack, b_txd;
    logic c_busy, c_ack, c_txd;

    uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .data_o(a_data), .send_req(a_req),
        .busy(a_busy), .send_ack(a_ack), .txd(a_txd));
    uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .data_o(b_data), .send_req(b_req),
        .busy(b_busy), .send_ack(b_ack), .txd(b_txd));
    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .data_o(c_data), .send_req(c_req),
        .busy(c_busy), .send_ack(c_ack), .txd(c_txd));

`ifdef UART_TX_PARITY_EN
    localparam int C_FRAME = 44;
`else
    localparam int C_FRAME = 40;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        logic [9:0]  fa, f55, f0f;
        logic [10:0] fb;
        logic [7:0]  got;
        logic        ex;
        logic [59:0] cbits;
        int          acks, bcnt;

        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        a_data = '0;  b_data = '0;  c_data = '0;
        repeat (3) @(negedge clk);
        chk("rst txd", 32'(a_txd), 1);
        chk("rst busy", 32'(a_busy), 0);
        chk("rst ack", 32'(a_ack), 0);
        chk("rst b txd", 32'(b_txd), 1);
        chk("rst c busy", 32'(c_busy), 0);

        // 0xA5 at one clock per bit: 0,1,0,1,0,0,1,0,1,1
        rst = 1'b0; a_req = 1'b1; a_data = 8'hA5;
        fa = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_req = 1'b0;
            chk($sformatf("a5 txd%0d", i), 32'(a_txd), 32'(fa[i]));
            chk($sformatf("a5 ack%0d", i), 32'(a_ack), (i == 9) ? 1 : 0);
            chk($sformatf("a5 busy%0d", i), 32'(a_busy), 1);
        end
        @(negedge clk);
        chk("a5 idle txd", 32'(a_txd), 1);
        chk("a5 idle busy", 32'(a_busy), 0);
        chk("a5 idle ack", 32'(a_ack), 0);

        // Back-to-back with send_req held: 0x55, one idle cycle, 0x0F
        a_req = 1'b1; a_data = 8'h55;
        f55 = 10'b1010101010;
        f0f = 10'b1000011110;
        acks = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            ex = (i < 10) ? f55[i] : (i == 10) ? 1'b1 : f0f[i - 11];
            chk($sformatf("b2b txd%0d", i), 32'(a_txd), 32'(ex));
            if (i == 10) chk("b2b gap busy", 32'(a_busy), 0);
            acks += int'(a_ack);
            if (i == 0) a_data = 8'h0F;
            if (i == 11) a_req = 1'b0;
        end
        @(negedge clk);
        chk("b2b acks", acks, 2);
        chk("b2b end busy", 32'(a_busy), 0);

        // data_o changes while busy must not reach the line
        a_req = 1'b1; a_data = 8'h3C;
        got = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_req = 1'b0; a_data = 8'hFF;
            if (i >= 1 && i <= 8) got[i - 1] = a_txd;
        end
        chk("hold 3c", 32'(got), 32'h3C);
        @(negedge clk);

        // Reset during data bit 3, send_req held through reset
        a_req = 1'b1; a_data = 8'h00;
        @(negedge clk);
        a_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid bit3 txd", 32'(a_txd), 0);
        chk("mid bit3 busy", 32'(a_busy), 1);
        rst = 1'b1; a_req = 1'b1; a_data = 8'h81;
        @(negedge clk);
        chk("abort txd", 32'(a_txd), 1);
        chk("abort busy", 32'(a_busy), 0);
        @(negedge clk);
        chk("req in rst busy", 32'(a_busy), 0);
        rst = 1'b0;
        fa = 10'b1100000010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_req = 1'b0;
            chk($sformatf("post rst txd%0d", i), 32'(a_txd), 32'(fa[i]));
            chk($sformatf("post rst ack%0d", i), 32'(a_ack), (i == 9) ? 1 : 0);
        end
        @(negedge clk);
        chk("post rst idle", 32'(a_busy), 0);

        // Two stop bits, two clocks per bit: 22-cycle frame, ack in last stop cycle
        b_req = 1'b1; b_data = 8'h96;
        fb = {2'b11, 8'h96, 1'b0};
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            b_req = 1'b0;
            chk($sformatf("s2 txd%0d", i), 32'(b_txd), 32'(fb[i / 2]));
            chk($sformatf("s2 ack%0d", i), 32'(b_ack), (i == 21) ? 1 : 0);
            chk($sformatf("s2 busy%0d", i), 32'(b_busy), 1);
        end
        @(negedge clk);
        chk("s2 end busy", 32'(b_busy), 0);
        chk("s2 end txd", 32'(b_txd), 1);

        // Four clocks per bit, 0x07: frame length and parity bit when enabled
        c_req = 1'b1; c_data = 8'h07;
        bcnt = 0; acks = 0; cbits = '1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            c_req = 1'b0;
            cbits[i] = c_txd;
            if (c_busy) bcnt++;
            acks += int'(c_ack);
        end
        chk("c busy len", bcnt, C_FRAME);
        chk("c acks", acks, 1);
        chk("c start", 32'(cbits[3:0]), 32'h0);
        chk("c data0", 32'(cbits[7:4]), 32'hF);
        chk("c data3", 32'(cbits[19:16]), 32'h0);
`ifdef UART_TX_PARITY_EN
        chk("c parity", 32'(cbits[39:36]), 32'hF);
        chk("c stop", 32'(cbits[43:40]), 32'hF);
`else
        chk("c stop", 32'(cbits[39:36]), 32'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clk cycles per serial bit; legal range 1..65535.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port data_o  input  8  byte to transmit; sampled only on the accept cycle.
REQ-006 Port send_req  input  1  request to transmit data_o; level-sensitive.
REQ-007 Port busy  output  1  high while a frame is in progress; registered.
REQ-008 Port send_ack  output  1  one-cycle pulse marking completion of a frame.
REQ-009 Port txd  output  1  serial line output; idle level 1; registered.

Function
REQ-010 FSM states: IDLE, START, DATA, PARITY (present only with UART_TX_PARITY_EN), STOP.
REQ-011 Accept rule: in IDLE with send_req=1, the block latches data_o into an internal shift register and moves to START on the next edge.
REQ-012 In START, txd=0 for exactly CLKS_PER_BIT cycles.
REQ-013 In DATA, the 8 bits are sent LSB first; each bit is held CLKS_PER_BIT cycles; a 3-bit index counts 0..7; the state exits after index 7.
REQ-014 In STOP, txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then the FSM returns to IDLE.
REQ-015 A 16-bit baud counter reloads at each bit boundary; bit advance occurs when count == CLKS_PER_BIT-1.
REQ-016 busy=1 in every non-IDLE state and 0 in IDLE; busy first rises on the edge that leaves IDLE.
REQ-017 send_ack=1 for exactly one cycle: the final clk cycle of the last stop bit.
REQ-018 Frame duration from the first start-bit cycle: (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
REQ-019 Back-to-back: if send_req=1 on the first IDLE cycle after send_ack, the next start bit begins one cycle later; the line carries exactly one idle-high cycle between frames.
REQ-020 send_req and changes to data_o while busy=1 are ignored; the frame in flight is not altered.
REQ-021 txd=1 in IDLE.
REQ-022 txd is driven from a register, so there are no combinational glitches on the line.

Reset
REQ-023 While rst=1 the FSM returns to IDLE on the next edge, even mid-frame; the partial frame is abandoned.
REQ-024 Reset values: txd=1, busy=0, send_ack=0, baud counter=0, bit index=0, shift register=0.
REQ-025 send_req asserted during rst=1 is not accepted; acceptance is first possible on the first cycle with rst=0.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: a PARITY state follows DATA; it drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-027 Macro UART_TX_PARITY_EN undefined: there is no PARITY state, DATA proceeds directly to STOP, and the frame is 1 bit shorter.

Verification
REQ-028 CLKS_PER_BIT=1, no parity, send_req pulse with data_o=0xA5 -> txd from the next cycle: 0,1,0,1,0,0,1,0,1,1; then idle 1; send_ack high on the stop-bit cycle only.
REQ-029 UART_TX_PARITY_EN, CLKS_PER_BIT=4, data_o=0x07 -> the parity bit is 1 for 4 cycles; frame length is 44 cycles; busy high for exactly 44 cycles.
REQ-030 send_req held high, data_o=0x55 then 0x0F -> two complete frames separated by one idle-1 cycle; two send_ack pulses.
REQ-031 rst=1 asserted during DATA bit 3 -> next cycle: txd=1, busy=0; a new send_req afterwards produces a clean full frame.
REQ-032 data_o changed from 0x3C to 0xFF while busy=1 -> the line still carries 0x3C.
REQ-033 STOP_BITS=2, CLKS_PER_BIT=2 -> the stop period is 4 cycles high; send_ack occurs in the 4th cycle.
